// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domain resets, then releases them one by one
// in ascending order, waiting (with a watchdog) for each domain's ack in between.
module reset_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ,
  input  logic [NUM_STAGES-1:0] STAGE_ACK,
  output logic [NUM_STAGES-1:0] STAGE_RST_N,
  output logic                  BUSY,
  output logic [3:0]            CUR_STAGE,
  output logic [NUM_STAGES-1:0] TIMEOUT_ERR
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_STAGE   = 4'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    HOLD,
    WAIT_ACK,
    GAP,
    IDLE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic [NUM_STAGES-1:0] err_q, err_d;
  logic [3:0]            cur_q, cur_d;

  logic                  ack_cur;
  logic [NUM_STAGES-1:0] cur_onehot;
  logic [NUM_STAGES-1:0] next_onehot;

  // Decode the awaited stage; acks of other stages never reach the FSM.
  always_comb begin
    ack_cur     = 1'b0;
    cur_onehot  = '0;
    next_onehot = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cur_q == 4'(i)) begin
        cur_onehot[i] = 1'b1;
        ack_cur       = STAGE_ACK[i];
      end
      if (cur_q + 4'd1 == 4'(i)) begin
        next_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= '0;
      cur_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
    end
  end

  // REQ overrides every other transition; a timeout is handled like a late ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    cur_d   = cur_q;
    err_d   = err_q;
    if (REQ) begin
      state_d = HOLD;
      cnt_d   = '0;
      rst_d   = '0;
      cur_d   = '0;
      err_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_d[0] = 1'b1;
            cur_d    = '0;
            cnt_d    = '0;
            state_d  = WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_cur || (cnt_q == TIMEOUT_LAST)) begin
            if (!ack_cur) begin
              err_d = err_q | cur_onehot;
            end
            cnt_d = '0;
            if (cur_q == LAST_STAGE) begin
              state_d = IDLE;
            end else if (GAP_CYCLES > 0) begin
              state_d = GAP;
            end else begin
              rst_d = rst_q | next_onehot;
              cur_d = cur_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            rst_d   = rst_q | next_onehot;
            cur_d   = cur_q + 4'd1;
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        IDLE: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    BUSY        = (state_q != IDLE);
    STAGE_RST_N = rst_q;
    CUR_STAGE   = cur_q;
    TIMEOUT_ERR = err_q;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: per-edge expectations are queued from the
// intended release timeline and popped one per rising edge.
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       rst_n_a, req_a;
  logic [2:0] ack_a;
  logic [2:0] stage_rst_n_a, err_a;
  logic       busy_a;
  logic [3:0] cur_a;

  logic       rst_n_b, req_b;
  logic [2:0] ack_b;
  logic [2:0] stage_rst_n_b, err_b;
  logic       busy_b;
  logic [3:0] cur_b;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0] rst;
    logic       busy;
    logic [3:0] cur;
    logic [2:0] err;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  reset_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK), .RST_N(rst_n_a), .REQ(req_a), .STAGE_ACK(ack_a),
    .STAGE_RST_N(stage_rst_n_a), .BUSY(busy_a), .CUR_STAGE(cur_a), .TIMEOUT_ERR(err_a)
  );

  reset_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)
  ) dut_g0 (
    .CLK(CLK), .RST_N(rst_n_b), .REQ(req_b), .STAGE_ACK(ack_b),
    .STAGE_RST_N(stage_rst_n_b), .BUSY(busy_b), .CUR_STAGE(cur_b), .TIMEOUT_ERR(err_b)
  );

  // Expected outputs after edge e, given the edges at which stages 0..2 are released,
  // the edge after which BUSY is low, and when a timeout mask appears.
  function automatic exp_t mk(int e, int r0, int r1, int r2, int idle_e, int err_e,
                              logic [2:0] err_v);
    exp_t x;
    x.rst  = {(e >= r2), (e >= r1), (e >= r0)};
    x.busy = (e < idle_e);
    x.cur  = (e >= r2) ? 4'd2 : (e >= r1) ? 4'd1 : 4'd0;
    x.err  = (e >= err_e) ? err_v : 3'b000;
    return x;
  endfunction

  task automatic test_reset();
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    #1;
    n_total++;
    if ({stage_rst_n_a, busy_a, cur_a, err_a} !== {3'b000, 1'b1, 4'd0, 3'b000})
      $display("[TB] FAIL reset_a: got rst=%b busy=%b cur=%0d err=%b, expected rst=000 busy=1 cur=0 err=000",
               stage_rst_n_a, busy_a, cur_a, err_a);
    else n_pass++;
    n_total++;
    if ({stage_rst_n_b, busy_b, cur_b, err_b} !== {3'b000, 1'b1, 4'd0, 3'b000})
      $display("[TB] FAIL reset_b: got rst=%b busy=%b cur=%0d err=%b, expected rst=000 busy=1 cur=0 err=000",
               stage_rst_n_b, busy_b, cur_b, err_b);
    else n_pass++;
  endtask

  task automatic test_normal_sequence();
    ack_a   = 3'b111;
    req_a   = 1'b0;
    rst_n_a = 1'b0;
    @(negedge CLK);
    rst_n_a = 1'b1;
    for (int e = 1; e <= 13; e++) sb.push_back(mk(e, 4, 7, 10, 11, 1000, 3'b000));
    for (int e = 1; e <= 13; e++) begin
      exp_t x;
      @(posedge CLK); #1;
      x = sb.pop_front();
      n_total++;
      if ({stage_rst_n_a, busy_a, cur_a, err_a} !== {x.rst, x.busy, x.cur, x.err})
        $display("[TB] FAIL normal_seq edge %0d: got rst=%b busy=%b cur=%0d err=%b, expected rst=%b busy=%b cur=%0d err=%b",
                 e, stage_rst_n_a, busy_a, cur_a, err_a, x.rst, x.busy, x.cur, x.err);
      else n_pass++;
    end
  endtask

  // Stage 1 never acks while stage 2 acks early: the wait stays on stage 1 until the
  // watchdog fires at edge 15, then the normal two-cycle gap precedes stage 2.
  task automatic test_timeout_early_ack();
    ack_a   = 3'b101;
    req_a   = 1'b0;
    rst_n_a = 1'b0;
    @(negedge CLK);
    rst_n_a = 1'b1;
    for (int e = 1; e <= 20; e++) sb.push_back(mk(e, 4, 7, 17, 18, 15, 3'b010));
    for (int e = 1; e <= 20; e++) begin
      exp_t x;
      @(posedge CLK); #1;
      x = sb.pop_front();
      n_total++;
      if ({stage_rst_n_a, busy_a, cur_a, err_a} !== {x.rst, x.busy, x.cur, x.err})
        $display("[TB] FAIL timeout edge %0d: got rst=%b busy=%b cur=%0d err=%b, expected rst=%b busy=%b cur=%0d err=%b",
                 e, stage_rst_n_a, busy_a, cur_a, err_a, x.rst, x.busy, x.cur, x.err);
      else n_pass++;
    end
  endtask

  task automatic test_req_restart();
    ack_a   = 3'b101;
    req_a   = 1'b0;
    rst_n_a = 1'b0;
    @(negedge CLK);
    rst_n_a = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      if (e <= 15) sb.push_back(mk(e, 4, 7, 17, 18, 15, 3'b010));
      else         sb.push_back(mk(e - 16, 4, 7, 10, 11, 1000, 3'b000));
    end
    for (int e = 1; e <= 28; e++) begin
      exp_t x;
      @(posedge CLK); #1;
      x = sb.pop_front();
      n_total++;
      if ({stage_rst_n_a, busy_a, cur_a, err_a} !== {x.rst, x.busy, x.cur, x.err})
        $display("[TB] FAIL req_restart edge %0d: got rst=%b busy=%b cur=%0d err=%b, expected rst=%b busy=%b cur=%0d err=%b",
                 e, stage_rst_n_a, busy_a, cur_a, err_a, x.rst, x.busy, x.cur, x.err);
      else n_pass++;
      if (e == 15) req_a = 1'b1;
      if (e == 16) begin
        req_a = 1'b0;
        ack_a = 3'b111;
      end
    end
  endtask

  // Starts from IDLE; REQ held across three edges keeps HOLD pinned at its start.
  task automatic test_req_held();
    ack_a = 3'b111;
    req_a = 1'b1;
    for (int e = 1; e <= 15; e++) sb.push_back(mk(e - 3, 4, 7, 10, 11, 1000, 3'b000));
    for (int e = 1; e <= 15; e++) begin
      exp_t x;
      @(posedge CLK); #1;
      x = sb.pop_front();
      n_total++;
      if ({stage_rst_n_a, busy_a, cur_a, err_a} !== {x.rst, x.busy, x.cur, x.err})
        $display("[TB] FAIL req_held edge %0d: got rst=%b busy=%b cur=%0d err=%b, expected rst=%b busy=%b cur=%0d err=%b",
                 e, stage_rst_n_a, busy_a, cur_a, err_a, x.rst, x.busy, x.cur, x.err);
      else n_pass++;
      if (e == 3) req_a = 1'b0;
    end
  endtask

  task automatic test_async_reset_mid_gap();
    exp_t x;
    ack_a   = 3'b101;
    req_a   = 1'b0;
    rst_n_a = 1'b0;
    @(negedge CLK);
    rst_n_a = 1'b1;
    repeat (15) @(posedge CLK);
    #1;
    sb.push_back(mk(15, 4, 7, 17, 18, 15, 3'b010));
    x = sb.pop_front();
    n_total++;
    if ({stage_rst_n_a, busy_a, cur_a, err_a} !== {x.rst, x.busy, x.cur, x.err})
      $display("[TB] FAIL pre_async_reset: got rst=%b busy=%b cur=%0d err=%b, expected rst=%b busy=%b cur=%0d err=%b",
               stage_rst_n_a, busy_a, cur_a, err_a, x.rst, x.busy, x.cur, x.err);
    else n_pass++;
    #2;
    rst_n_a = 1'b0;
    #1;
    n_total++;
    if ({stage_rst_n_a, busy_a, cur_a, err_a} !== {3'b000, 1'b1, 4'd0, 3'b000})
      $display("[TB] FAIL async_reset_mid_gap: got rst=%b busy=%b cur=%0d err=%b, expected rst=000 busy=1 cur=0 err=000",
               stage_rst_n_a, busy_a, cur_a, err_a);
    else n_pass++;
  endtask

  // Zero gap: consecutive releases, then acks drop in IDLE without effect.
  task automatic test_gap_zero();
    ack_b   = 3'b111;
    req_b   = 1'b0;
    rst_n_b = 1'b0;
    @(negedge CLK);
    rst_n_b = 1'b1;
    for (int e = 1; e <= 10; e++) sb.push_back(mk(e, 4, 5, 6, 7, 1000, 3'b000));
    for (int e = 1; e <= 10; e++) begin
      exp_t x;
      @(posedge CLK); #1;
      x = sb.pop_front();
      n_total++;
      if ({stage_rst_n_b, busy_b, cur_b, err_b} !== {x.rst, x.busy, x.cur, x.err})
        $display("[TB] FAIL gap_zero edge %0d: got rst=%b busy=%b cur=%0d err=%b, expected rst=%b busy=%b cur=%0d err=%b",
                 e, stage_rst_n_b, busy_b, cur_b, err_b, x.rst, x.busy, x.cur, x.err);
      else n_pass++;
      if (e == 7) ack_b = 3'b000;
    end
  endtask

  initial begin
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    req_a   = 1'b0;
    req_b   = 1'b0;
    ack_a   = 3'b000;
    ack_b   = 3'b000;
    #2;
    test_reset();
    test_normal_sequence();
    test_timeout_early_ack();
    test_req_restart();
    test_req_held();
    test_async_reset_mid_gap();
    test_gap_zero();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
